x_cmd_ctrl: RTL

X_CMD_CTRL -- requirements
Module: x_cmd_ctrl

---
 rtl/x_cmd_pkg.sv | 33 +++
 rtl/x_sync2.sv | 25 ++
 rtl/x_cmd_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/x_cmd_pkg.sv
// Shared types and byte constants for the UART command controller.
// Holds the FSM state encoding and the command/response byte values.
package x_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  localparam logic [7:0] cmd_write = 8'h57;
  localparam logic [7:0] cmd_read  = 8'h52;
  localparam logic [7:0] rsp_ack   = 8'h4B;
  localparam logic [7:0] rsp_err   = 8'h3F;

  localparam logic [1:0] last_wr_idx = 2'd3;

  // Places a received write byte into its little-endian lane of the partial word.
  function automatic logic [23:0] insert_byte(input logic [23:0] shadow,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  data);
    logic [23:0] res;
    res = shadow;
    case (idx)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res        = shadow;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/x_sync2.sv
// Two-flop synchroniser for a bus sampled from another clock domain.
// Both stages clear on synchronous reset.
module x_sync2 #(
  parameter int p_width = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_d,
  output logic [p_width-1:0] o_q
);

  logic [p_width-1:0] meta_r;

  // Two register stages to let metastability resolve before use.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_r <= {p_width{1'b0}};
      o_q    <= {p_width{1'b0}};
    end else begin
      meta_r <= i_d;
      o_q    <= meta_r;
    end
  end

endmodule

// File: rtl/x_cmd_ctrl.sv
// UART byte command controller: 'W' + 4 bytes writes o_data, 'R' returns the
// synchronised i_data LSB first, anything else answers '?'.
module x_cmd_ctrl
  import x_cmd_pkg::*;
#(
  parameter int p_clk_hz         = 48000000,
  parameter int p_timeout_cycles = p_clk_hz / 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_ready,
  output logic [31:0] o_data,
  input  logic [31:0] i_data,
  output logic        o_overrun
);

  localparam int cnt_w = $clog2(p_timeout_cycles + 1);
  localparam logic [cnt_w-1:0] to_last = cnt_w'(p_timeout_cycles - 1);

  state_t           state_r;
  logic [1:0]       idx_r;
  logic [23:0]      wr_shadow_r;
  logic [23:0]      tx_shadow_r;
  logic [1:0]       tx_rem_r;
  logic [cnt_w-1:0] to_cnt_r;
  logic [31:0]      data_sync_s;

  x_sync2 #(.p_width(32)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_data),
    .o_q   (data_sync_s)
  );

  // Command FSM; every output is registered so o_tx_valid never sees i_tx_ready combinationally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      wr_shadow_r <= 24'd0;
      tx_shadow_r <= 24'd0;
      tx_rem_r    <= 2'd0;
      to_cnt_r    <= {cnt_w{1'b0}};
      o_tx_valid  <= 1'b0;
      o_tx_byte   <= 8'd0;
      o_data      <= 32'd0;
      o_overrun   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          to_cnt_r <= {cnt_w{1'b0}};
          if (i_rx_valid) begin
            if (i_rx_byte == cmd_write) begin
              state_r <= ST_WR_DATA;
              idx_r   <= 2'd0;
            end else if (i_rx_byte == cmd_read) begin
              // First byte goes straight out; the upper three wait in the shadow.
              o_tx_byte   <= data_sync_s[7:0];
              tx_shadow_r <= data_sync_s[31:8];
              tx_rem_r    <= 2'd3;
              o_tx_valid  <= 1'b1;
              state_r     <= ST_SEND;
            end else begin
              o_tx_byte  <= rsp_err;
              tx_rem_r   <= 2'd0;
              o_tx_valid <= 1'b1;
              state_r    <= ST_SEND;
            end
          end
        end

        ST_WR_DATA: begin
          if (i_rx_valid) begin
            to_cnt_r <= {cnt_w{1'b0}};
            if (idx_r == last_wr_idx) begin
              o_data     <= {i_rx_byte, wr_shadow_r};
              o_tx_byte  <= rsp_ack;
              tx_rem_r   <= 2'd0;
              o_tx_valid <= 1'b1;
              state_r    <= ST_SEND;
              idx_r      <= 2'd0;
            end else begin
              wr_shadow_r <= insert_byte(wr_shadow_r, idx_r, i_rx_byte);
              idx_r       <= idx_r + 2'd1;
            end
          end else if (to_cnt_r == to_last) begin
            // Stalled write: drop it silently, o_data keeps its old value.
            to_cnt_r <= {cnt_w{1'b0}};
            idx_r    <= 2'd0;
            state_r  <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
          end
        end

        ST_SEND: begin
          if (i_rx_valid) begin
            o_overrun <= 1'b1;
          end
          if (o_tx_valid && i_tx_ready) begin
            if (tx_rem_r == 2'd0) begin
              o_tx_valid <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              o_tx_byte   <= tx_shadow_r[7:0];
              tx_shadow_r <= {8'd0, tx_shadow_r[23:8]};
              tx_rem_r    <= tx_rem_r - 2'd1;
            end
          end
        end

        default: begin
          o_tx_valid <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
